// File: rtl/ex_mem_stage_buf_if.sv
// rtl/ex_mem_stage_buf_if.sv - EX->MEM stage handshake and payload bundle
interface ex_mem_stage_buf_if #(
   parameter int WB_W   = 2,
   parameter int M_W    = 2,
   parameter int DATA_W = 32,
   parameter int RID_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [WB_W-1:0]   WB_IN;
   logic [M_W-1:0]    M_IN;
   logic [DATA_W-1:0] ALU_resultIN;
   logic [DATA_W-1:0] Mem_WDataIN;
   logic [RID_W-1:0]  Reg_WIDIN;
   logic              out_valid;
   logic              out_ready;
   logic [WB_W-1:0]   WB_OUT;
   logic [M_W-1:0]    M_OUT;
   logic [DATA_W-1:0] ALU_resultOUT;
   logic [DATA_W-1:0] Mem_WDataOUT;
   logic [RID_W-1:0]  Reg_WIDOUT;
   logic [1:0]        occ;

   modport master (
      output in_valid, WB_IN, M_IN, ALU_resultIN, Mem_WDataIN, Reg_WIDIN, out_ready,
      input  in_ready, out_valid, WB_OUT, M_OUT, ALU_resultOUT, Mem_WDataOUT, Reg_WIDOUT, occ
   );

   modport slave (
      input  in_valid, WB_IN, M_IN, ALU_resultIN, Mem_WDataIN, Reg_WIDIN, out_ready,
      output in_ready, out_valid, WB_OUT, M_OUT, ALU_resultOUT, Mem_WDataOUT, Reg_WIDOUT, occ
   );
endinterface

// File: rtl/ex_mem_stage_buf.sv
// rtl/ex_mem_stage_buf.sv - EX->MEM pipeline register with 2-entry skid buffer
module ex_mem_stage_buf #(
   parameter int              WB_W      = 2,
   parameter int              M_W       = 2,
   parameter int              DATA_W    = 32,
   parameter int              RID_W     = 5,
   parameter logic [WB_W-1:0] WB_BUBBLE = 2'b01,
   parameter logic [M_W-1:0]  M_BUBBLE  = 2'b00
) (
   input logic               clk,
   input logic               reset,
   input logic               flush,
   ex_mem_stage_buf_if.slave bus
);
   localparam int PW = WB_W + M_W + 2 * DATA_W + RID_W;
   localparam logic [PW-1:0] BUBBLE = {WB_BUBBLE, M_BUBBLE, {(2 * DATA_W + RID_W){1'b0}}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] head, head_n;
   logic [PW-1:0] skid, skid_n;
   logic [PW-1:0] in_pl;
   logic          in_ready, out_valid, in_fire, out_fire;

   // Handshake flags come only from the state register, so out_ready never reaches in_ready.
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign in_fire   = bus.in_valid & in_ready;
   assign out_fire  = out_valid & bus.out_ready;

   assign in_pl = {bus.WB_IN, bus.M_IN, bus.ALU_resultIN, bus.Mem_WDataIN, bus.Reg_WIDIN};

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.occ       = state;
   assign {bus.WB_OUT, bus.M_OUT, bus.ALU_resultOUT, bus.Mem_WDataOUT, bus.Reg_WIDOUT} = head;

   always_comb begin
      state_n = state;
      head_n  = head;
      skid_n  = skid;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               head_n  = in_pl;
               state_n = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               head_n = in_pl;
            end else if (in_fire) begin
               skid_n  = in_pl;
               state_n = TWO;
            end else if (out_fire) begin
               head_n  = BUBBLE;
               state_n = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               head_n  = skid;
               skid_n  = BUBBLE;
               state_n = ONE;
            end
         end
         default: begin
            head_n  = BUBBLE;
            skid_n  = BUBBLE;
            state_n = EMPTY;
         end
      endcase
   end

   // Flush behaves exactly like reset; any same-cycle input is simply dropped.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state <= EMPTY;
         head  <= BUBBLE;
         skid  <= BUBBLE;
      end else begin
         state <= state_n;
         head  <= head_n;
         skid  <= skid_n;
      end
   end
endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// tb/tb_ex_mem_stage_buf.sv - directed and random checks against a queue model
module tb_ex_mem_stage_buf;
   localparam int WB_W = 2, M_W = 2, DATA_W = 32, RID_W = 5;

   typedef struct packed {
      logic [1:0]  wb;
      logic [1:0]  m;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  rid;
   } pl_t;

   logic clk = 1'b0;
   logic reset, flush;
   int   checks = 0;
   int   errors = 0;
   pl_t  q[$];
   pl_t  bub;
   pl_t  p;

   always #5 clk = ~clk;

   ex_mem_stage_buf_if #(.WB_W(WB_W), .M_W(M_W), .DATA_W(DATA_W), .RID_W(RID_W)) bus ();

   ex_mem_stage_buf #(
      .WB_W(WB_W), .M_W(M_W), .DATA_W(DATA_W), .RID_W(RID_W),
      .WB_BUBBLE(2'b01), .M_BUBBLE(2'b00)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .bus  (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pl_t rnd_pl();
      pl_t r;
      r.wb  = 2'($urandom);
      r.m   = 2'($urandom);
      r.alu = $urandom;
      r.wd  = $urandom;
      r.rid = 5'($urandom);
      return r;
   endfunction

   task automatic drive(input bit iv, input bit ordy, input pl_t x);
      bus.in_valid     = iv;
      bus.out_ready    = ordy;
      bus.WB_IN        = x.wb;
      bus.M_IN         = x.m;
      bus.ALU_resultIN = x.alu;
      bus.Mem_WDataIN  = x.wd;
      bus.Reg_WIDIN    = x.rid;
   endtask

   // Expected outputs: head of the model FIFO, or the bubble when it is empty.
   task automatic check_state(input string tag);
      pl_t e;
      e = (q.size() != 0) ? q[0] : bub;
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
      chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(q.size() != 2));
      chk({tag, "_occ"},       64'(bus.occ),       64'(q.size()));
      chk({tag, "_wb"},        64'(bus.WB_OUT),        64'(e.wb));
      chk({tag, "_m"},         64'(bus.M_OUT),         64'(e.m));
      chk({tag, "_alu"},       64'(bus.ALU_resultOUT), 64'(e.alu));
      chk({tag, "_wdata"},     64'(bus.Mem_WDataOUT),  64'(e.wd));
      chk({tag, "_rid"},       64'(bus.Reg_WIDOUT),    64'(e.rid));
   endtask

   task automatic step(input string tag, input bit do_check);
      bit   inf, outf;
      pl_t  inp;
      #1;
      if (do_check) check_state(tag);
      inf = bus.in_valid && (q.size() != 2);
      outf = bus.out_ready && (q.size() != 0);
      inp = '{bus.WB_IN, bus.M_IN, bus.ALU_resultIN, bus.Mem_WDataIN, bus.Reg_WIDIN};
      @(posedge clk);
      if (reset || flush) begin
         q.delete();
      end else begin
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(inp);
      end
      @(negedge clk);
   endtask

   initial begin
      bub = '{wb: 2'b01, m: 2'b00, alu: 32'h0, wd: 32'h0, rid: 5'h0};
      reset = 1'b1;
      flush = 1'b0;
      @(negedge clk);

      // 1: reset with live input
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'($urandom), rnd_pl());
         step("reset_hold", 1'b0);
      end
      reset = 1'b0;
      drive(1'b0, 1'b1, rnd_pl());
      step("after_reset", 1'b1);

      // 2: streaming at full rate
      for (int i = 0; i < 8; i++) begin
         p = rnd_pl();
         p.alu = 32'h100 + 32'(i);
         p.rid = 5'(i);
         drive(1'b1, 1'b1, p);
         step("stream", 1'b1);
      end
      drive(1'b0, 1'b1, rnd_pl());
      step("stream_drain", 1'b1);
      step("stream_empty", 1'b1);

      // 3: fill skid, hold C off, then drain in order
      p = rnd_pl(); p.alu = 32'hAAAA0001; drive(1'b1, 1'b0, p); step("fill_a", 1'b1);
      p = rnd_pl(); p.alu = 32'hBBBB0002; drive(1'b1, 1'b0, p); step("fill_b", 1'b1);
      p = rnd_pl(); p.alu = 32'hCCCC0003;
      drive(1'b1, 1'b0, p); step("full_hold_c", 1'b1);
      drive(1'b1, 1'b0, p); step("full_hold_c2", 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, p); step("drain_c", 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, rnd_pl()); step("drain_end", 1'b1);
      end

      // 4: simultaneous in/out fire while holding one entry
      drive(1'b1, 1'b0, rnd_pl()); step("one_load", 1'b1);
      p = rnd_pl(); p.alu = 32'h12345678; drive(1'b1, 1'b1, p); step("one_swap", 1'b1);
      drive(1'b0, 1'b0, rnd_pl()); step("one_swap_chk", 1'b1);

      // 5: flush at occupancy two with an input offered
      drive(1'b1, 1'b0, rnd_pl()); step("pre_flush", 1'b1);
      p = rnd_pl(); p.alu = 32'h0000DEAD;
      drive(1'b1, 1'($urandom), p);
      flush = 1'b1;
      step("flush_cyc", 1'b1);
      flush = 1'b0;
      drive(1'b0, 1'b1, rnd_pl());
      step("after_flush", 1'b1);
      step("after_flush2", 1'b1);

      // 6: reset mid-stream with out_ready toggling, then restart stream
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'(i & 1), rnd_pl()); step("toggle", 1'b1);
      end
      drive(1'b1, 1'b0, rnd_pl()); step("toggle_fill", 1'b1);
      reset = 1'b1;
      drive(1'b1, 1'b1, rnd_pl()); step("mid_reset", 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p = rnd_pl();
         p.alu = 32'h100 + 32'(i);
         p.rid = 5'(i);
         drive(1'b1, 1'b1, p);
         step("restream", 1'b1);
      end

      // random traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rnd_pl());
         flush = ($urandom_range(0, 39) == 0);
         step("random", 1'b1);
      end
      flush = 1'b0;
      drive(1'b0, 1'b1, rnd_pl());
      for (int i = 0; i < 3; i++) step("final_drain", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_mem_stage_buf.md
Name: ex_mem_stage_buf

Overview:
- Parametrised EX→MEM pipeline stage register, the successor to the plain EX/MEM latch.
- Carries the WB control, M control, ALU result, store data and destination register ID.
- Adds a valid/ready handshake, a 2-entry skid buffer so upstream sees a registered ready, synchronous flush, and bubble insertion so an empty stage never drives write enables.
- Sits between the EX stage and the data-memory stage.

Parameters:
WB_W, 2, width of WB control field
M_W, 2, width of M control field
DATA_W, 32, width of ALU result and store data
RID_W, 5, width of destination register ID
WB_BUBBLE, 2'b01, WB value driven when the stage holds no valid instruction
M_BUBBLE, 2'b00, M value driven when the stage holds no valid instruction

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all held entries
in_valid  input  1  EX presents a valid instruction
in_ready  output  1  stage can accept; registered, equals (occ != 2)
WB_IN  input  WB_W  WB control from EX
M_IN  input  M_W  M control from EX
ALU_resultIN  input  DATA_W  ALU result
Mem_WDataIN  input  DATA_W  store data
Reg_WIDIN  input  RID_W  destination register ID
out_valid  output  1  MEM-side entry is valid
out_ready  input  1  MEM stage consumes entry
WB_OUT  output  WB_W  head-entry WB control
M_OUT  output  M_W  head-entry M control
ALU_resultOUT  output  DATA_W  head-entry ALU result
Mem_WDataOUT  output  DATA_W  head-entry store data
Reg_WIDOUT  output  RID_W  head-entry register ID
occ  output  2  number of held entries (0..2)

Behaviour:
- Storage is a head register, which drives all *_OUT ports directly, plus one skid register. The occupancy state is EMPTY(0), ONE(1) or TWO(2).
- Bubble: WB=WB_BUBBLE, M=M_BUBBLE, ALU result/store data/register ID all zero, valid=0.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = (occ != 0).
  - in_ready and out_valid are purely functions of registered state, with no combinational path from out_ready.
- Reset (synchronous, highest priority): head and skid load bubble, occ=0. After reset edge: out_valid=0, in_ready=1, WB_OUT=WB_BUBBLE, M_OUT=M_BUBBLE, ALU_resultOUT=0, Mem_WDataOUT=0, Reg_WIDOUT=0.
- Flush (priority below reset, above everything else): same effect as reset. A same-cycle in_fire is discarded, and a same-cycle out_fire still counts as consumed by MEM.
- Transitions (no reset, no flush):
  - EMPTY, in_fire: head ← input, go to ONE.
  - ONE, in_fire & out_fire: head ← input, stay in ONE.
  - ONE, in_fire only: skid ← input, go to TWO. in_ready drops next cycle.
  - ONE, out_fire only: head ← bubble, go to EMPTY.
  - TWO (in_ready=0), out_fire: head ← skid, skid ← bubble, go to ONE.
  - Any other combination: hold all state.
- Latency is 1 cycle, input to *_OUT. Sustained throughput is 1/cycle when out_ready stays high.
- Order is strictly FIFO, with no reordering or duplication.
- Fields are copied verbatim with no arithmetic; widths are exactly the parameter widths.
- in_valid while in_ready=0 is a legal hold: upstream keeps its data and the stage ignores it.
- Held *_OUT values must stay stable while out_valid=1 and out_ready=0.

Test Plan:
1. Assert reset 2 cycles with random inputs and in_valid=1 -> after the edge, out_valid=0, in_ready=1, occ=0, WB_OUT=2'b01, M_OUT=2'b00, other outputs 0.
2. Stream 8 instructions (ALU_resultIN=0x100+i, Reg_WIDIN=i) with out_ready=1 -> each appears on the next cycle, occ stays 1, in_ready stays 1, no gaps.
3. Send A=0xAAAA0001 and B=0xBBBB0002 with out_ready=0 -> occ=2, in_ready=0 and C is held off; raise out_ready -> A, then B, then C in order, and WB_OUT/M_OUT return to bubble after the drain.
4. In ONE, apply in_fire and out_fire in the same cycle with payload 0x12345678 -> occ stays 1 and the head shows 0x12345678 next cycle.
5. At occ=2, assert flush together with in_valid=1 (payload 0xDEAD) -> next cycle occ=0, out_valid=0, in_ready=1, outputs are bubble, and 0xDEAD never appears.
6. Assert reset at occ=2 mid-stream with out_ready toggling -> bubble outputs next cycle; the stream restarted afterwards behaves as in scenario 2.
